seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 22 ++
 rtl/seq_divider.sv | 136 +++++++++++++
 tb/tb_seq_divider.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Constants are held at 64 bits so any XLEN up to 64 can slice them.
package div_pkg;

  localparam int unsigned DIV_XLEN    = 32;
  localparam int unsigned DIV_CONST_W = 64;

  localparam logic [DIV_CONST_W-1:0] DIV_ALL_ONES = '1;
  localparam logic [DIV_CONST_W-1:0] DIV_MOST_NEG = {1'b1, {(DIV_CONST_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor when it fits, and emit the resulting quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  assign shifted = {rem_in, dvd_bit};
  assign q_bit   = (shifted >= {1'b0, dvs});
  // The partial remainder stays below the divisor, so the difference fits in XLEN bits.
  assign rem_out = q_bit ? XLEN'(shifted - {1'b0, dvs}) : shifted[XLEN-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_FASTPATH_EN to send divide-by-zero and signed overflow straight to DONE.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned     CNT_W    = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);
  localparam logic [XLEN-1:0] ONES     = DIV_ALL_ONES[XLEN-1:0];
  localparam logic [XLEN-1:0] MOST_NEG = DIV_MOST_NEG[DIV_CONST_W-1 -: XLEN];
  localparam logic [XLEN-1:0] ONE      = XLEN'(1);

  function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ((~v) + ONE) : v;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  dq_q, rem_q, dvs_q, dvd_raw_q;
  logic             neg_quot_q, neg_rem_q, dz_q, ovf_q;
  logic [XLEN-1:0]  quot_q, remo_q;
  logic [XLEN-1:0]  fin_quot, fin_rem;
  logic [XLEN-1:0]  step_rem;
  logic             step_q;
  logic             accept, dz_in, ovf_in, last_iter, iterate;

  assign accept    = in_valid && (state_q == IDLE) && !flush;
  assign dz_in     = (divisor == '0);
  assign ovf_in    = is_signed && (dividend == MOST_NEG) && (divisor == ONES);
  assign last_iter = (state_q == CALC) && (cnt_q == LAST_CNT);
  assign iterate   = (state_q == CALC) && (cnt_q != LAST_CNT);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = remo_q;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dq_q[XLEN-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
`ifdef DIV_ZERO_FASTPATH_EN
          if (dz_in || ovf_in) state_d = DONE;
`endif
        end
      end
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush outranks every handshake, including one arriving in IDLE.
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cnt_q <= '0;
      else if (iterate) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Magnitudes are formed at acceptance; dq_q shifts dividend bits out and quotient bits in.
  always_ff @(posedge clk) begin
    if (accept) begin
      dq_q       <= cond_negate(dividend, is_signed && dividend[XLEN-1]);
      dvs_q      <= cond_negate(divisor, is_signed && divisor[XLEN-1]);
      rem_q      <= '0;
      dvd_raw_q  <= dividend;
      neg_quot_q <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_rem_q  <= is_signed && dividend[XLEN-1];
      dz_q       <= dz_in;
      ovf_q      <= ovf_in;
    end else if (iterate) begin
      dq_q  <= {dq_q[XLEN-2:0], step_q};
      rem_q <= step_rem;
    end
  end

  always_comb begin
    fin_quot = cond_negate(dq_q, neg_quot_q);
    fin_rem  = cond_negate(rem_q, neg_rem_q);
    if (dz_q) begin
      fin_quot = ONES;
      fin_rem  = dvd_raw_q;
    end else if (ovf_q) begin
      fin_quot = dvd_raw_q;
      fin_rem  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      remo_q <= '0;
    end else if (last_iter && !flush) begin
      quot_q <= fin_quot;
      remo_q <= fin_rem;
    end
`ifdef DIV_ZERO_FASTPATH_EN
    else if (accept && (dz_in || ovf_in)) begin
      quot_q <= dz_in ? ONES : dividend;
      remo_q <= dz_in ? dividend : '0;
    end
`endif
  end

endmodule

// File: tb/tb_seq_divider.sv
// Table-driven scoreboard bench for seq_divider, plus stall, flush and reset sequences.
module tb_seq_divider;

  logic        clk, rst_n, in_valid, in_ready, is_signed, flush, out_valid, out_ready;
  logic [31:0] dividend, divisor, quotient, remainder;

  seq_divider #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    time         t_acc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[15];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   was_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef DIV_ZERO_FASTPATH_EN
    if (b == 32'h0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 33;
  endfunction

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input bit expect_out);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue%0d_timeout: in_ready %b required 1", id, in_ready);
      return;
    end
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    if (expect_out) begin
      e.id = id; e.q = eq; e.r = er; e.lat = exp_latency(a, b, s); e.t_acc = $time;
      sbq.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Scoreboard: compare each result on the first cycle its out_valid is seen.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !was_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: q=%h r=%h with no request outstanding", quotient, remainder);
      end else begin
        e = sbq.pop_front();
        check($sformatf("vec%0d_quot", e.id), {32'h0, quotient}, {32'h0, e.q});
        check($sformatf("vec%0d_rem", e.id), {32'h0, remainder}, {32'h0, e.r});
        check($sformatf("vec%0d_latency", e.id), 64'(($time - e.t_acc - 5) / 10), 64'(e.lat));
      end
    end
    was_valid = out_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  seen;
    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1};
    vecs[3]  = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678};
    vecs[4]  = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678};
    vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
    vecs[7]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    vecs[8]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF};
    vecs[9]  = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9};
    vecs[10] = '{32'd9,          32'd3,          1'b0, 32'd3,          32'd0};
    vecs[11] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0};
    vecs[12] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0};
    vecs[13] = '{32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0};
    vecs[14] = '{32'hDEAD_BEEF,  32'h10,         1'b0, 32'h0DEA_DBEE,  32'hF};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", {63'h0, out_valid}, 64'h0);
    check("reset_quot", {32'h0, quotient}, 64'h0);
    check("reset_rem", {32'h0, remainder}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", {63'h0, in_ready}, 64'h1);

    for (int i = 0; i < 15; i++) begin
      issue(i, vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, vecs[i].q, vecs[i].r, 1'b1);
      drain();
    end

    // Consumer stalls for 10 cycles in DONE.
    out_ready = 1'b0;
    issue(100, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("stall_valid_rose", {63'h0, out_valid}, 64'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_quot", i), {32'h0, quotient}, 64'd14);
      check($sformatf("stall%0d_rem", i), {32'h0, remainder}, 64'd2);
      check($sformatf("stall%0d_ready_valid", i), {62'h0, in_ready, out_valid}, 64'b01);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_ready_valid", {62'h0, in_ready, out_valid}, 64'b10);
    drain();

    // Flush during CALC: the operation must vanish.
    issue(200, 32'd1000, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_ready_valid", {62'h0, in_ready, out_valid}, 64'b10);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_output", {63'h0, seen}, 64'h0);
    issue(201, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b1);
    drain();

    // Flush in IDLE blocks a simultaneous request.
    @(negedge clk);
    dividend = 32'd5; divisor = 32'd1; is_signed = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_no_accept", {63'h0, in_ready}, 64'h1);

    // Reset in the middle of CALC.
    issue(300, 32'd12345, 32'd11, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {63'h0, out_valid}, 64'h0);
    check("midreset_quot", {32'h0, quotient}, 64'h0);
    check("midreset_rem", {32'h0, remainder}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", {63'h0, in_ready}, 64'h1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midreset_no_output", {63'h0, seen}, 64'h0);
    issue(301, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
